// File: rtl/database_arbiter.sv
// Round-robin arbiter giving NUM_STAGES classifier stages shared read access
// to one database memory, with one read in flight at a time.
module database_arbiter #(
    parameter int NUM_STAGES    = 4,
    parameter int DATA_WIDTH_12 = 12,
    parameter int MEM_LATENCY   = 2
) (
    input  logic                                clk_fpga,
    input  logic                                reset_fpga,
    input  logic [NUM_STAGES-1:0]               req,
    input  logic [NUM_STAGES*DATA_WIDTH_12-1:0] req_addr,
    input  logic                                flush,
    input  logic [DATA_WIDTH_12-1:0]            mem_rdata,
    output logic                                o_mem_ren,
    output logic [DATA_WIDTH_12-1:0]            o_mem_addr,
    output logic [NUM_STAGES-1:0]               o_grant,
    output logic [DATA_WIDTH_12-1:0]            o_rdata,
    output logic [NUM_STAGES-1:0]               o_rdata_valid,
    output logic                                o_busy
);

    localparam int PTR_W = $clog2(NUM_STAGES);
    localparam int PW1   = PTR_W + 1;
    localparam int CNT_W = $clog2(MEM_LATENCY + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]               state;
    logic [PTR_W-1:0]         rr_ptr;
    logic [PTR_W-1:0]         gnt_idx;
    logic [PTR_W-1:0]         win_idx;
    logic                     win_found;
    logic [PW1-1:0]           cand;
    logic [CNT_W-1:0]         lat_cnt;
    logic [DATA_WIDTH_12-1:0] addr_q;
    logic [NUM_STAGES-1:0]    gnt_onehot;

    // Search upward from rr_ptr; cand carries one extra bit so the wrap works for any NUM_STAGES
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            cand = {1'b0, rr_ptr} + PW1'(i);
            if (cand >= PW1'(NUM_STAGES))
                cand = cand - PW1'(NUM_STAGES);
            if (!win_found && req[cand[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[PTR_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_fpga or negedge reset_fpga) begin
        if (!reset_fpga) begin
            state   <= S_IDLE;
            rr_ptr  <= '0;
            gnt_idx <= '0;
            lat_cnt <= '0;
            addr_q  <= '0;
            o_rdata <= '0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        gnt_idx <= win_idx;
                        addr_q  <= req_addr[int'(win_idx)*DATA_WIDTH_12 +: DATA_WIDTH_12];
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    lat_cnt <= CNT_W'(MEM_LATENCY);
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    lat_cnt <= lat_cnt - 1'b1;
                    if (lat_cnt == CNT_W'(1)) begin
                        o_rdata <= mem_rdata;
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    rr_ptr <= (gnt_idx == PTR_W'(NUM_STAGES - 1)) ? '0 : gnt_idx + 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        gnt_onehot          = '0;
        gnt_onehot[gnt_idx] = 1'b1;
    end

    // A flush during DONE aborts the return, so the valid strobe is suppressed too
    assign o_busy        = (state != S_IDLE);
    assign o_mem_ren     = (state == S_ISSUE);
    assign o_mem_addr    = addr_q;
    assign o_grant       = o_busy ? gnt_onehot : '0;
    assign o_rdata_valid = ((state == S_DONE) && !flush) ? gnt_onehot : '0;

endmodule

// File: tb/tb_database_arbiter.sv
// Bench for database_arbiter: cycle-exact vector table plus sequences for
// continuous round-robin traffic and asynchronous reset mid-transaction.
module tb_database_arbiter;

    typedef struct {
        logic [3:0]  rq;
        logic [11:0] a0, a1, a2, a3;
        logic        fl;
        logic        busy;
        logic        ren;
        logic [11:0] maddr;
        logic [3:0]  grant;
        logic [3:0]  valid;
        logic [11:0] rdata;
    } vec_t;

    logic        clk_fpga;
    logic        reset_fpga;
    logic [3:0]  req;
    logic [47:0] req_addr;
    logic        flush;
    logic [11:0] mem_rdata;
    logic        o_mem_ren;
    logic [11:0] o_mem_addr;
    logic [3:0]  o_grant;
    logic [11:0] o_rdata;
    logic [3:0]  o_rdata_valid;
    logic        o_busy;

    logic [11:0] mem_p0, mem_p1;
    int          n_checks;
    int          n_err;
    vec_t        vecs[$];

    database_arbiter #(
        .NUM_STAGES(4),
        .DATA_WIDTH_12(12),
        .MEM_LATENCY(2)
    ) dut (
        .clk_fpga(clk_fpga),
        .reset_fpga(reset_fpga),
        .req(req),
        .req_addr(req_addr),
        .flush(flush),
        .mem_rdata(mem_rdata),
        .o_mem_ren(o_mem_ren),
        .o_mem_addr(o_mem_addr),
        .o_grant(o_grant),
        .o_rdata(o_rdata),
        .o_rdata_valid(o_rdata_valid),
        .o_busy(o_busy)
    );

    initial clk_fpga = 1'b0;
    always #5 clk_fpga = ~clk_fpga;

    function automatic logic [11:0] mem_fn(input logic [11:0] a);
        return a ^ 12'h364;
    endfunction

    // Two-cycle memory model: data for an address strobed in cycle t is on mem_rdata in cycle t+2
    always @(posedge clk_fpga) begin
        mem_p0 <= o_mem_ren ? mem_fn(o_mem_addr) : 12'hEEE;
        mem_p1 <= mem_p0;
    end
    assign mem_rdata = mem_p1;

    function automatic vec_t mk(input logic [3:0] rq, input logic [11:0] a0, input logic [11:0] a1,
                                input logic [11:0] a2, input logic [11:0] a3, input logic fl,
                                input logic b, input logic r, input logic [11:0] m,
                                input logic [3:0] g, input logic [3:0] v, input logic [11:0] d);
        vec_t t;
        t.rq = rq; t.a0 = a0; t.a1 = a1; t.a2 = a2; t.a3 = a3; t.fl = fl;
        t.busy = b; t.ren = r; t.maddr = m; t.grant = g; t.valid = v; t.rdata = d;
        return t;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input int idx, input logic b, input logic r,
                            input logic [11:0] m, input logic [3:0] g, input logic [3:0] v,
                            input logic [11:0] d);
        chk({tag, " busy"},  idx, 32'(o_busy), 32'(b));
        chk({tag, " ren"},   idx, 32'(o_mem_ren), 32'(r));
        chk({tag, " addr"},  idx, 32'(o_mem_addr), 32'(m));
        chk({tag, " grant"}, idx, 32'(o_grant), 32'(g));
        chk({tag, " valid"}, idx, 32'(o_rdata_valid), 32'(v));
        chk({tag, " rdata"}, idx, 32'(o_rdata), 32'(d));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [11:0] addrs[4];
        logic [3:0]  ev;
        logic        found;
        int          cyc, last_cyc;

        n_checks = 0;
        n_err    = 0;

        // Single read from stage 1
        vecs.push_back(mk(4'h2, 12'h000, 12'h0A5, 12'h000, 12'h000, 1'b0, 1'b0, 1'b0, 12'h000, 4'h0, 4'h0, 12'h000));
        vecs.push_back(mk(4'h0, 12'h000, 12'h0A5, 12'h000, 12'h000, 1'b0, 1'b1, 1'b1, 12'h0A5, 4'h2, 4'h0, 12'h000));
        vecs.push_back(mk(4'h0, 12'h000, 12'h0A5, 12'h000, 12'h000, 1'b0, 1'b1, 1'b0, 12'h0A5, 4'h2, 4'h0, 12'h000));
        vecs.push_back(mk(4'h0, 12'h000, 12'h0A5, 12'h000, 12'h000, 1'b0, 1'b1, 1'b0, 12'h0A5, 4'h2, 4'h0, 12'h000));
        vecs.push_back(mk(4'h0, 12'h000, 12'h0A5, 12'h000, 12'h000, 1'b0, 1'b1, 1'b0, 12'h0A5, 4'h2, 4'h2, 12'h3C1));
        vecs.push_back(mk(4'h0, 12'h000, 12'h0A5, 12'h000, 12'h000, 1'b0, 1'b0, 1'b0, 12'h0A5, 4'h0, 4'h0, 12'h3C1));
        // rr_ptr=2, req=1001 held: stage 3 first, then stage 0
        vecs.push_back(mk(4'h9, 12'h200, 12'h000, 12'h000, 12'h123, 1'b0, 1'b0, 1'b0, 12'h0A5, 4'h0, 4'h0, 12'h3C1));
        vecs.push_back(mk(4'h9, 12'h200, 12'h000, 12'h000, 12'h123, 1'b0, 1'b1, 1'b1, 12'h123, 4'h8, 4'h0, 12'h3C1));
        vecs.push_back(mk(4'h9, 12'h200, 12'h000, 12'h000, 12'h123, 1'b0, 1'b1, 1'b0, 12'h123, 4'h8, 4'h0, 12'h3C1));
        vecs.push_back(mk(4'h9, 12'h200, 12'h000, 12'h000, 12'h123, 1'b0, 1'b1, 1'b0, 12'h123, 4'h8, 4'h0, 12'h3C1));
        vecs.push_back(mk(4'h9, 12'h200, 12'h000, 12'h000, 12'h123, 1'b0, 1'b1, 1'b0, 12'h123, 4'h8, 4'h8, 12'h247));
        vecs.push_back(mk(4'h9, 12'h200, 12'h000, 12'h000, 12'h123, 1'b0, 1'b0, 1'b0, 12'h123, 4'h0, 4'h0, 12'h247));
        vecs.push_back(mk(4'h9, 12'h200, 12'h000, 12'h000, 12'h123, 1'b0, 1'b1, 1'b1, 12'h200, 4'h1, 4'h0, 12'h247));
        vecs.push_back(mk(4'h9, 12'h200, 12'h000, 12'h000, 12'h123, 1'b0, 1'b1, 1'b0, 12'h200, 4'h1, 4'h0, 12'h247));
        vecs.push_back(mk(4'h9, 12'h200, 12'h000, 12'h000, 12'h123, 1'b0, 1'b1, 1'b0, 12'h200, 4'h1, 4'h0, 12'h247));
        vecs.push_back(mk(4'h0, 12'h200, 12'h000, 12'h000, 12'h123, 1'b0, 1'b1, 1'b0, 12'h200, 4'h1, 4'h1, 12'h164));
        vecs.push_back(mk(4'h0, 12'h200, 12'h000, 12'h000, 12'h123, 1'b0, 1'b0, 1'b0, 12'h200, 4'h0, 4'h0, 12'h164));
        // rr_ptr=1: stage 2 flushed in WAIT, flush in IDLE blocks a grant, then stage 1 from unchanged rr_ptr
        vecs.push_back(mk(4'h4, 12'h000, 12'h0B1, 12'h0F0, 12'h0C3, 1'b0, 1'b0, 1'b0, 12'h200, 4'h0, 4'h0, 12'h164));
        vecs.push_back(mk(4'h0, 12'h000, 12'h0B1, 12'h0F0, 12'h0C3, 1'b0, 1'b1, 1'b1, 12'h0F0, 4'h4, 4'h0, 12'h164));
        vecs.push_back(mk(4'h0, 12'h000, 12'h0B1, 12'h0F0, 12'h0C3, 1'b1, 1'b1, 1'b0, 12'h0F0, 4'h4, 4'h0, 12'h164));
        vecs.push_back(mk(4'hA, 12'h000, 12'h0B1, 12'h0F0, 12'h0C3, 1'b1, 1'b0, 1'b0, 12'h0F0, 4'h0, 4'h0, 12'h164));
        vecs.push_back(mk(4'hA, 12'h000, 12'h0B1, 12'h0F0, 12'h0C3, 1'b0, 1'b0, 1'b0, 12'h0F0, 4'h0, 4'h0, 12'h164));
        vecs.push_back(mk(4'h0, 12'h000, 12'h0B1, 12'h0F0, 12'h0C3, 1'b0, 1'b1, 1'b1, 12'h0B1, 4'h2, 4'h0, 12'h164));
        vecs.push_back(mk(4'h0, 12'h000, 12'h0B1, 12'h0F0, 12'h0C3, 1'b0, 1'b1, 1'b0, 12'h0B1, 4'h2, 4'h0, 12'h164));
        vecs.push_back(mk(4'h0, 12'h000, 12'h0B1, 12'h0F0, 12'h0C3, 1'b0, 1'b1, 1'b0, 12'h0B1, 4'h2, 4'h0, 12'h164));
        vecs.push_back(mk(4'h0, 12'h000, 12'h0B1, 12'h0F0, 12'h0C3, 1'b0, 1'b1, 1'b0, 12'h0B1, 4'h2, 4'h2, 12'h3D5));
        vecs.push_back(mk(4'h0, 12'h000, 12'h0B1, 12'h0F0, 12'h0C3, 1'b0, 1'b0, 1'b0, 12'h0B1, 4'h0, 4'h0, 12'h3D5));
        // Stage 0 address changes during WAIT; the in-flight read keeps 0x010
        vecs.push_back(mk(4'h1, 12'h010, 12'h000, 12'h000, 12'h000, 1'b0, 1'b0, 1'b0, 12'h0B1, 4'h0, 4'h0, 12'h3D5));
        vecs.push_back(mk(4'h0, 12'h010, 12'h000, 12'h000, 12'h000, 1'b0, 1'b1, 1'b1, 12'h010, 4'h1, 4'h0, 12'h3D5));
        vecs.push_back(mk(4'h0, 12'h020, 12'h000, 12'h000, 12'h000, 1'b0, 1'b1, 1'b0, 12'h010, 4'h1, 4'h0, 12'h3D5));
        vecs.push_back(mk(4'h0, 12'h020, 12'h000, 12'h000, 12'h000, 1'b0, 1'b1, 1'b0, 12'h010, 4'h1, 4'h0, 12'h3D5));
        vecs.push_back(mk(4'h0, 12'h020, 12'h000, 12'h000, 12'h000, 1'b0, 1'b1, 1'b0, 12'h010, 4'h1, 4'h1, 12'h374));
        vecs.push_back(mk(4'h0, 12'h020, 12'h000, 12'h000, 12'h000, 1'b0, 1'b0, 1'b0, 12'h010, 4'h0, 4'h0, 12'h374));

        reset_fpga = 1'b0;
        req        = 4'h0;
        req_addr   = '0;
        flush      = 1'b0;
        @(negedge clk_fpga);
        @(negedge clk_fpga);
        #1;
        chk_outs("reset", 0, 1'b0, 1'b0, 12'h000, 4'h0, 4'h0, 12'h000);
        @(negedge clk_fpga);
        reset_fpga = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            req      = vecs[i].rq;
            req_addr = {vecs[i].a3, vecs[i].a2, vecs[i].a1, vecs[i].a0};
            flush    = vecs[i].fl;
            #1;
            chk_outs("vec", i, vecs[i].busy, vecs[i].ren, vecs[i].maddr, vecs[i].grant,
                     vecs[i].valid, vecs[i].rdata);
            @(negedge clk_fpga);
        end
        req   = 4'h0;
        flush = 1'b0;

        // All stages requesting continuously from reset
        reset_fpga = 1'b0;
        @(negedge clk_fpga);
        @(negedge clk_fpga);
        addrs[0] = 12'h111; addrs[1] = 12'h222; addrs[2] = 12'h333; addrs[3] = 12'h3FF;
        req_addr   = {addrs[3], addrs[2], addrs[1], addrs[0]};
        req        = 4'hF;
        reset_fpga = 1'b1;
        cyc      = 0;
        last_cyc = 0;
        for (int k = 0; k < 5; k++) begin
            found = 1'b0;
            for (int w = 0; w < 12; w++) begin
                @(negedge clk_fpga);
                #1;
                cyc++;
                if (o_rdata_valid != 4'h0) begin
                    found = 1'b1;
                    break;
                end
            end
            ev         = 4'h0;
            ev[k % 4]  = 1'b1;
            chk("rr return seen", k, 32'(found), 32'(1));
            chk("rr valid", k, 32'(o_rdata_valid), 32'(ev));
            chk("rr grant", k, 32'(o_grant), 32'(ev));
            chk("rr rdata", k, 32'(o_rdata), 32'(mem_fn(addrs[k % 4])));
            if (k == 0)
                chk("rr first latency", k, 32'(cyc), 32'(4));
            else
                chk("rr spacing", k, 32'(cyc - last_cyc), 32'(5));
            last_cyc = cyc;
            if (k == 4)
                req = 4'h0;
        end

        // Asynchronous reset in WAIT, then a clean stage-2 read after release
        @(negedge clk_fpga);
        req_addr = {12'h000, 12'h2A2, 12'h000, 12'h000};
        req      = 4'h4;
        @(negedge clk_fpga);
        req = 4'h0;
        @(negedge clk_fpga);
        #1;
        chk("pre-reset busy", 0, 32'(o_busy), 32'(1));
        #1;
        reset_fpga = 1'b0;
        #1;
        chk_outs("async reset", 0, 1'b0, 1'b0, 12'h000, 4'h0, 4'h0, 12'h000);
        @(negedge clk_fpga);
        #1;
        chk("in reset valid", 0, 32'(o_rdata_valid), 32'(0));
        @(negedge clk_fpga);
        req        = 4'h4;
        reset_fpga = 1'b1;
        found = 1'b0;
        cyc   = 0;
        for (int w = 0; w < 12; w++) begin
            @(negedge clk_fpga);
            #1;
            cyc++;
            req = 4'h0;
            if (o_rdata_valid != 4'h0) begin
                found = 1'b1;
                break;
            end
        end
        chk("post-reset return seen", 0, 32'(found), 32'(1));
        chk("post-reset latency", 0, 32'(cyc), 32'(4));
        chk("post-reset valid", 0, 32'(o_rdata_valid), 32'(4'h4));
        chk("post-reset rdata", 0, 32'(o_rdata), 32'(mem_fn(12'h2A2)));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/database_arbiter.md
DATABASE_ARBITER -- requirements
Module: database_arbiter

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 4: number of classifier-stage requesters sharing one database memory; legal range 2..32.
REQ-002 SHALL have parameter DATA_WIDTH_12, default 12: width of the database address and the database data word.
REQ-003 SHALL have parameter MEM_LATENCY, default 2: cycles from the memory read strobe to valid memory data; legal range 1..8.
REQ-004 Port clk_fpga, input, 1: the single clock; all state changes on its rising edge.
REQ-005 Port reset_fpga, input, 1: asynchronous, active-low reset.
REQ-006 Port req, input, NUM_STAGES: per-stage read request level.
REQ-007 Port req_addr, input, NUM_STAGES*DATA_WIDTH_12: flattened per-stage database address; stage i occupies bits [i*12+11 : i*12].
REQ-008 Port flush, input, 1: synchronous abort of the current transaction.
REQ-009 Port mem_rdata, input, DATA_WIDTH_12: database memory read data.
REQ-010 Port o_mem_ren, output, 1: one-cycle database memory read strobe.
REQ-011 Port o_mem_addr, output, DATA_WIDTH_12: database memory address.
REQ-012 Port o_grant, output, NUM_STAGES: one-hot owner of the current transaction.
REQ-013 Port o_rdata, output, DATA_WIDTH_12: captured read data.
REQ-014 Port o_rdata_valid, output, NUM_STAGES: one-hot, one-cycle data-return strobe.
REQ-015 Port o_busy, output, 1: high whenever the state is not IDLE.

Function
REQ-016 SHALL implement the states IDLE, ISSUE, WAIT and DONE, with one transaction in flight at most.
REQ-017 In IDLE with req nonzero, the block SHALL select the first requesting stage at or after rr_ptr, searching upward with wrap from NUM_STAGES-1 to 0.
- On that edge it SHALL register the winner index g and req_addr[g].
- It SHALL then enter ISSUE.
REQ-018 In IDLE with req == 0, the block SHALL remain in IDLE.
REQ-019 In ISSUE (cycle t):
- o_mem_ren SHALL be 1 and o_mem_addr SHALL equal the registered address.
- A latency counter SHALL load MEM_LATENCY, and the next state SHALL be WAIT.
REQ-020 In WAIT, the counter SHALL decrement each cycle.
- In cycle t+MEM_LATENCY, mem_rdata SHALL be captured into o_rdata.
- The next state SHALL then be DONE.
REQ-021 In DONE (cycle t+MEM_LATENCY+1):
- o_rdata_valid[g] SHALL be 1 for exactly this cycle.
- rr_ptr SHALL become (g+1) mod NUM_STAGES.
- The next state SHALL be IDLE.
REQ-022 o_grant SHALL be one-hot at bit g from ISSUE through DONE inclusive, and 0 in IDLE.
REQ-023 Request-to-data latency SHALL be MEM_LATENCY+2 cycles from the IDLE sampling edge to o_rdata_valid, and the minimum request spacing SHALL be MEM_LATENCY+3 cycles per transaction.
REQ-024 The block SHALL sample req_addr[g] only at the grant edge; later changes to req_addr SHALL NOT affect the transaction in flight.
REQ-025 A req still high in the IDLE cycle after DONE SHALL be treated as a new request; because rr_ptr has advanced, every other pending stage SHALL be served first.
REQ-026 Changes to req for other stages during ISSUE, WAIT or DONE SHALL NOT affect the transaction in flight.
REQ-027 flush high in any state SHALL force IDLE at the next edge.
- o_rdata_valid SHALL NOT be asserted for the aborted transaction.
- rr_ptr and o_rdata SHALL keep their values.
- If flush is high in ISSUE, o_mem_ren SHALL still be 1 in that cycle.
REQ-028 flush in IDLE SHALL block grants for that cycle only.
REQ-029 o_mem_ren SHALL be 0 outside ISSUE; o_mem_addr SHALL hold the last issued address outside ISSUE.
REQ-030 rr_ptr SHALL have width clog2(NUM_STAGES) and SHALL wrap from NUM_STAGES-1 to 0.

Reset
REQ-031 While reset_fpga is 0, the block SHALL asynchronously force:
- state to IDLE and rr_ptr to 0;
- o_mem_ren, o_mem_addr, o_grant, o_rdata, o_rdata_valid and o_busy to 0.
REQ-032 Reset asserted mid-transaction SHALL abandon that transaction with no o_rdata_valid.
REQ-033 After reset release, the first grant SHALL follow rr_ptr = 0.

Verification
REQ-034 Single request, MEM_LATENCY=2: req=0010, req_addr[1]=0x0A5, memory returns 0x3C1 -> o_mem_ren high for one cycle with o_mem_addr=0x0A5, o_grant=0010, and o_rdata_valid=0010 with o_rdata=0x3C1 four cycles after the sampling edge.
REQ-035 All stages requesting continuously from reset -> grants in the order 0,1,2,3,0, with o_rdata_valid spaced 5 cycles apart.
REQ-036 Stage 3 served, then req=1001 held -> the next grant goes to stage 0, not stage 3.
REQ-037 flush asserted in WAIT for stage 2 -> no o_rdata_valid, o_busy low on the next cycle, and the next grant starts from rr_ptr unchanged.
REQ-038 reset_fpga driven low mid-WAIT, asynchronously between clock edges -> all outputs 0 immediately; after release with req=0100, stage 2 is granted and its data returns normally.
REQ-039 req_addr[0] changed from 0x010 to 0x020 during WAIT -> o_mem_addr stays 0x010 and o_rdata matches the data for 0x010.
